// File: rtl/dbus_axil_router.sv
// dbus_axil_router: steers the CPU simple data bus to the data BRAM, an
// AXI4-lite master port, or an internal decode-error responder. Only one
// transaction is in flight at a time. Responses from the AXI and error paths
// are registered, so they appear one cycle after the event that completes them.
module dbus_axil_router #(
  parameter int          DATAMEM_DEPTH = 8192,
  parameter logic [31:0] AXI_BASE      = 32'h4000_0000,
  parameter logic [31:0] AXI_SIZE      = 32'h1000_0000,
  parameter int          TIMEOUT       = 1024
) (
  input  logic                             clk,
  input  logic                             rstf,
  input  logic                             dBus_cmd_valid,
  output logic                             dBus_cmd_ready,
  input  logic [31:0]                      dBus_cmd_payload_addr,
  input  logic [31:0]                      dBus_cmd_payload_data,
  input  logic [1:0]                       dBus_cmd_payload_size,
  input  logic                             dBus_cmd_payload_wr,
  output logic                             dBus_rsp_valid,
  output logic [31:0]                      dBus_rsp_data,
  output logic                             dBus_rsp_error,
  output logic [$clog2(DATAMEM_DEPTH)-1:0] datamem_addr,
  output logic [31:0]                      datamem_wdata,
  output logic [3:0]                       datamem_mask,
  output logic                             datamem_we,
  output logic                             datamem_valid,
  input  logic                             datamem_ready,
  input  logic [31:0]                      datamem_rdata,
  input  logic                             datamem_rvalid,
  output logic [31:0]                      m_axi_awaddr,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [2:0]                       m_axi_awprot,
  output logic [31:0]                      m_axi_wdata,
  output logic [3:0]                       m_axi_wstrb,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic [31:0]                      m_axi_araddr,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  output logic [2:0]                       m_axi_arprot,
  input  logic [31:0]                      m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int          AW      = $clog2(DATAMEM_DEPTH);
  localparam int          CW      = $clog2(TIMEOUT) + 1;
  localparam logic [32:0] MEM_TOP = 33'(DATAMEM_DEPTH) << 2;

  typedef enum logic [2:0] {IDLE, MEM_RD, AXI_WR, AXI_B, AXI_AR, AXI_R} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          aw_pend, w_pend;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    strb_q;
  logic          cmd_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_data_q;

  logic          is_mem, is_axi, accept, tmo, mem_ready;
  logic [3:0]    strb;
  logic          done, done_rsp, done_err;
  logic [31:0]   done_data;

  // Address decode and byte strobes from access size
  always_comb begin
    is_mem = {1'b0, dBus_cmd_payload_addr} < MEM_TOP;
    is_axi = (dBus_cmd_payload_addr & ~(AXI_SIZE - 32'd1)) == AXI_BASE;
    case (dBus_cmd_payload_size)
      2'd0:    strb = 4'b0001 << dBus_cmd_payload_addr[1:0];
      2'd1:    strb = 4'b0011 << {dBus_cmd_payload_addr[1], 1'b0};
      default: strb = 4'b1111;
    endcase
  end

  // The IDLE cycle carrying a registered response still sees the old
  // command's valid, so sampling is held off for that one cycle.
  assign accept = (state == IDLE) && !cmd_ready_q && dBus_cmd_valid;
  assign tmo    = (cnt == CW'(TIMEOUT - 1));

  // Next state, AXI handshakes and response launch
  always_comb begin
    state_nxt     = state;
    datamem_valid = 1'b0;
    mem_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    done          = 1'b0;
    done_rsp      = 1'b0;
    done_err      = 1'b0;
    done_data     = 32'd0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mem) begin
            datamem_valid = 1'b1;
            mem_ready     = datamem_ready;
            if (datamem_ready && !dBus_cmd_payload_wr) state_nxt = MEM_RD;
          end else if (is_axi) begin
            state_nxt = dBus_cmd_payload_wr ? AXI_WR : AXI_AR;
          end else begin
            done     = 1'b1;
            done_rsp = 1'b1;
            done_err = 1'b1;
          end
        end
      end
      MEM_RD: begin
        if (datamem_rvalid) state_nxt = IDLE;
      end
      AXI_WR: begin
        if (tmo) begin
          done = 1'b1; done_rsp = 1'b1; done_err = 1'b1; state_nxt = IDLE;
        end else begin
          m_axi_awvalid = aw_pend;
          m_axi_wvalid  = w_pend;
          if ((!aw_pend || m_axi_awready) && (!w_pend || m_axi_wready)) state_nxt = AXI_B;
        end
      end
      AXI_B: begin
        if (tmo) begin
          done = 1'b1; done_rsp = 1'b1; done_err = 1'b1; state_nxt = IDLE;
        end else begin
          m_axi_bready = 1'b1;
          if (m_axi_bvalid) begin
            done      = 1'b1;
            done_rsp  = (m_axi_bresp != 2'b00);
            done_err  = (m_axi_bresp != 2'b00);
            state_nxt = IDLE;
          end
        end
      end
      AXI_AR: begin
        if (tmo) begin
          done = 1'b1; done_rsp = 1'b1; done_err = 1'b1; state_nxt = IDLE;
        end else begin
          m_axi_arvalid = 1'b1;
          if (m_axi_arready) state_nxt = AXI_R;
        end
      end
      AXI_R: begin
        if (tmo) begin
          done = 1'b1; done_rsp = 1'b1; done_err = 1'b1; state_nxt = IDLE;
        end else begin
          m_axi_rready = 1'b1;
          if (m_axi_rvalid) begin
            done      = 1'b1;
            done_rsp  = 1'b1;
            done_err  = (m_axi_rresp != 2'b00);
            done_data = m_axi_rdata;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, AXI latches, watchdog and registered response
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state       <= IDLE;
      cnt         <= '0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      strb_q      <= 4'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      state       <= state_nxt;
      cmd_ready_q <= done;
      rsp_valid_q <= done_rsp;
      rsp_err_q   <= done_err;
      rsp_data_q  <= done_data;
      if (state == IDLE && (state_nxt == AXI_WR || state_nxt == AXI_AR)) begin
        cnt     <= '0;
        addr_q  <= dBus_cmd_payload_addr;
        wdata_q <= dBus_cmd_payload_data;
        strb_q  <= strb;
        aw_pend <= 1'b1;
        w_pend  <= 1'b1;
      end else if (state == AXI_WR || state == AXI_B || state == AXI_AR || state == AXI_R) begin
        cnt <= cnt + CW'(1);
      end
      if (state == AXI_WR) begin
        if (m_axi_awvalid && m_axi_awready) aw_pend <= 1'b0;
        if (m_axi_wvalid && m_axi_wready)   w_pend  <= 1'b0;
      end
    end
  end

  assign datamem_addr   = dBus_cmd_payload_addr[AW+1:2];
  assign datamem_wdata  = dBus_cmd_payload_data;
  assign datamem_mask   = dBus_cmd_payload_wr ? strb : 4'b1111;
  assign datamem_we     = dBus_cmd_payload_wr;

  assign m_axi_awaddr   = addr_q;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_wdata    = wdata_q;
  assign m_axi_wstrb    = strb_q;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arprot   = 3'b000;

  assign dBus_cmd_ready = cmd_ready_q | mem_ready;
  assign dBus_rsp_valid = rsp_valid_q | ((state == MEM_RD) && datamem_rvalid);
  assign dBus_rsp_data  = (state == MEM_RD) ? datamem_rdata : rsp_data_q;
  assign dBus_rsp_error = rsp_err_q;

endmodule

// File: tb/tb_dbus_axil_router.sv
// Bench for dbus_axil_router: directed transactions; expected responses are
// queued with their expected cycle and matched by a response monitor.
module tb_dbus_axil_router;

  localparam int DEPTH = 64;

  logic        clk, rstf;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_data;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_data;
  logic [5:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [3:0]  dm_mask;
  logic        dm_we, dm_valid, dm_ready, dm_rvalid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  dbus_axil_router #(.DATAMEM_DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk(clk), .rstf(rstf),
    .dBus_cmd_valid(cmd_valid), .dBus_cmd_ready(cmd_ready),
    .dBus_cmd_payload_addr(cmd_addr), .dBus_cmd_payload_data(cmd_data),
    .dBus_cmd_payload_size(cmd_size), .dBus_cmd_payload_wr(cmd_wr),
    .dBus_rsp_valid(rsp_valid), .dBus_rsp_data(rsp_data), .dBus_rsp_error(rsp_error),
    .datamem_addr(dm_addr), .datamem_wdata(dm_wdata), .datamem_mask(dm_mask),
    .datamem_we(dm_we), .datamem_valid(dm_valid), .datamem_ready(dm_ready),
    .datamem_rdata(dm_rdata), .datamem_rvalid(dm_rvalid),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_awprot(awprot),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_arprot(arprot),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic w);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_size = s; cmd_wr = w;
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e, input logic r, input int c);
    exp_t x;
    x.data = d; x.err = e; x.rd = r; x.cyc = c;
    exp_q.push_back(x);
  endtask

  // Response monitor: every rsp pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rstf && rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("rsp_cycle", cyc, x.cyc);
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, x.err});
        if (x.rd) chk("rsp_data", rsp_data, x.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rstf = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_data = 32'd0; cmd_size = 2'd0;
    cmd_wr = 1'b0; dm_ready = 1'b0; dm_rdata = 32'd0; dm_rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
    repeat (3) tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_error, |rsp_data}, 32'd0);
    chk("rst_axi_valids", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("rst_dm_valid", {31'd0, dm_valid}, 32'd0);
    rstf = 1'b1;
    tick();

    // MEM writes, back to back, with word/half/byte strobes
    dm_ready = 1'b1;
    drive(32'h10, 32'hDEADBEEF, 2'd2, 1'b1); #1;
    chk("memw_valid", {31'd0, dm_valid}, 32'd1);
    chk("memw_addr", {26'd0, dm_addr}, 32'd4);
    chk("memw_mask", {28'd0, dm_mask}, 32'hF);
    chk("memw_we", {31'd0, dm_we}, 32'd1);
    chk("memw_wdata", dm_wdata, 32'hDEADBEEF);
    chk("memw_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    drive(32'h22, 32'h0, 2'd1, 1'b1); #1;
    chk("memw_half_mask", {28'd0, dm_mask}, 32'hC);
    chk("memw_half_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    drive(32'hFD, 32'h0, 2'd0, 1'b1); #1;
    chk("memw_byte_mask", {28'd0, dm_mask}, 32'h2);
    chk("memw_top_addr", {26'd0, dm_addr}, 32'd63);
    tick();
    cmd_valid = 1'b0; dm_ready = 1'b0;
    tick();

    // AXI byte write: wready immediate, awready after 3 cycles
    wready = 1'b1;
    drive(32'h4000_0003, 32'h0000_00AA, 2'd0, 1'b1);
    tick();
    chk("axw_awvalid0", {31'd0, awvalid}, 32'd1);
    chk("axw_wvalid0", {31'd0, wvalid}, 32'd1);
    chk("axw_wstrb", {28'd0, wstrb}, 32'h8);
    chk("axw_awaddr", awaddr, 32'h4000_0003);
    tick();
    chk("axw_wvalid_drop", {31'd0, wvalid}, 32'd0);
    chk("axw_awvalid1", {31'd0, awvalid}, 32'd1);
    tick();
    chk("axw_awvalid2", {31'd0, awvalid}, 32'd1);
    tick();
    chk("axw_awvalid3", {31'd0, awvalid}, 32'd1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk("axw_awvalid_drop", {31'd0, awvalid}, 32'd0);
    chk("axw_bready", {31'd0, bready}, 32'd1);
    chk("axw_ready_early", {31'd0, cmd_ready}, 32'd0);
    bvalid = 1'b1; bresp = 2'd0;
    tick();
    bvalid = 1'b0;
    chk("axw_done_ready", {31'd0, cmd_ready}, 32'd1);
    chk("axw_bready_drop", {31'd0, bready}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();

    // AXI write with error response
    awready = 1'b1;
    drive(32'h4000_0008, 32'h0BAD_F00D, 2'd2, 1'b1);
    tick();
    chk("axwe_wstrb", {28'd0, wstrb}, 32'hF);
    chk("axwe_wdata", wdata, 32'h0BAD_F00D);
    tick();
    awready = 1'b0;
    bvalid = 1'b1; bresp = 2'b11;
    expect_rsp(32'd0, 1'b1, 1'b0, cyc + 1);
    tick();
    bvalid = 1'b0; bresp = 2'd0;
    chk("axwe_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    tick();

    // AXI read with SLVERR
    arready = 1'b1;
    drive(32'h4000_0100, 32'h0, 2'd2, 1'b0);
    tick();
    chk("axr_arvalid", {31'd0, arvalid}, 32'd1);
    chk("axr_araddr", araddr, 32'h4000_0100);
    tick();
    arready = 1'b0;
    chk("axr_arvalid_drop", {31'd0, arvalid}, 32'd0);
    chk("axr_rready", {31'd0, rready}, 32'd1);
    tick();
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
    expect_rsp(32'h1234_5678, 1'b1, 1'b1, cyc + 1);
    tick();
    rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
    chk("axr_ready", {31'd0, cmd_ready}, 32'd1);
    chk("axr_rready_drop", {31'd0, rready}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();

    // Unmapped read just past BRAM, and write just past the AXI window
    drive(32'h100, 32'h0, 2'd2, 1'b0);
    k = cyc;
    expect_rsp(32'd0, 1'b1, 1'b1, k + 1);
    #1;
    chk("err_no_dm", {31'd0, dm_valid}, 32'd0);
    tick();
    chk("err_ready", {31'd0, cmd_ready}, 32'd1);
    chk("err_no_axi", {30'd0, arvalid, awvalid}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    drive(32'h5000_0000, 32'h1, 2'd2, 1'b1);
    expect_rsp(32'd0, 1'b1, 1'b0, cyc + 1);
    tick();
    chk("errw_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    tick();
    drive(32'h2000_0000, 32'h0, 2'd2, 1'b0);
    expect_rsp(32'd0, 1'b1, 1'b1, cyc + 1);
    tick();
    chk("err2_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    tick();

    // Watchdog: arready never comes
    drive(32'h4000_0200, 32'h0, 2'd2, 1'b0);
    k = cyc;
    expect_rsp(32'd0, 1'b1, 1'b1, k + 17);
    repeat (10) tick();
    chk("tmo_arvalid_mid", {31'd0, arvalid}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) break;
      tick();
    end
    chk("tmo_ready_seen", {31'd0, cmd_ready}, 32'd1);
    chk("tmo_latency", cyc - k, 32'd17);
    chk("tmo_arvalid_after", {31'd0, arvalid}, 32'd0);
    tick();
    cmd_valid = 1'b0;
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("tmo_late_rready", {31'd0, rready}, 32'd0);
    tick();
    rvalid = 1'b0;
    tick();

    // Reset during AXI_B, then a MEM read
    awready = 1'b1;
    drive(32'h4000_0010, 32'h5, 2'd2, 1'b1);
    tick();
    tick();
    awready = 1'b0;
    chk("rstb_bready_before", {31'd0, bready}, 32'd1);
    rstf = 1'b0;
    #1;
    chk("rstb_axi", {27'd0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
    chk("rstb_rsp", {30'd0, cmd_ready, rsp_valid}, 32'd0);
    chk("rstb_dm", {31'd0, dm_valid}, 32'd0);
    cmd_valid = 1'b0;
    tick();
    rstf = 1'b1;
    tick();
    dm_ready = 1'b1;
    drive(32'h8, 32'h0, 2'd2, 1'b0); #1;
    chk("memr_addr", {26'd0, dm_addr}, 32'd2);
    chk("memr_mask", {28'd0, dm_mask}, 32'hF);
    chk("memr_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0; dm_ready = 1'b0;
    #1;
    chk("memr_wait", {31'd0, rsp_valid}, 32'd0);
    tick();
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
    expect_rsp(32'hCAFE_F00D, 1'b0, 1'b1, cyc);
    tick();
    dm_rvalid = 1'b0; dm_rdata = 32'd0;
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
